// File: rtl/sevenseg_pkg.sv
// Shared constants, digit pattern table, FSM states and pattern decoder
// for the multiplexed 7-segment bus monitor.
package sevenseg_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam int unsigned NUM_CODES = 10;

  // Active-high segment patterns (bit0=a .. bit6=g) for digits 0..9
  localparam logic [6:0] DIGIT_PAT [NUM_CODES] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_e;

  // Returns {err, bcd}; unknown patterns give {1, 4'hF}
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'h1F;
    for (int i = 0; i < NUM_CODES; i++) begin
      if (pat == DIGIT_PAT[i]) res = {1'b0, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/sevenseg_decoder_filter.sv
// Input register, legal-anode check and stability counter; emits a one-cycle
// capture strobe with the digit index and raw (active-low) segment pattern.
module seg_stability_filter
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [NUM_DIGITS-1:0] an_in,
  output logic                  cap,
  output logic [IW-1:0]         cap_idx,
  output logic [7:0]            cap_seg
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned LW = $clog2(NUM_DIGITS + 1);

  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  state_e                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         lat_idx;
  logic [7:0]            lat_seg;
  logic [LW-1:0]         nlow;
  logic [IW-1:0]         idx;
  logic                  legal;

  // Exactly one low anode bit selects a digit; anything else is blanking
  always_comb begin
    nlow = '0;
    idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        nlow = nlow + LW'(1);
        idx  = IW'(i);
      end
    end
    legal = (nlow == LW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q   <= '0;
      an_q    <= '0;
      state   <= IDLE;
      cnt     <= '0;
      lat_idx <= '0;
      lat_seg <= '0;
      cap     <= 1'b0;
    end else begin
      seg_q <= seg_in;
      an_q  <= an_in;
      cap   <= 1'b0;
      if (!legal) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (state == IDLE || idx != lat_idx || seg_q != lat_seg) begin
        lat_idx <= idx;
        lat_seg <= seg_q;
        cnt     <= CW'(1);
        state   <= SETTLE;
      end else if (state == SETTLE) begin
        if (cnt == CW'(STABLE_CYCLES - 1)) begin
          cnt   <= CW'(STABLE_CYCLES);
          state <= HOLD;
          cap   <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign cap_idx = lat_idx;
  assign cap_seg = lat_seg;

endmodule

// File: rtl/sevenseg_decoder.sv
// Reconstructs the displayed BCD frame from a multiplexed active-low
// 7-segment bus; publishes a frame once every digit has been captured.
module sevenseg_decoder
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned STABLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              SevenSeg,
  input  logic [NUM_DIGITS-1:0]   Anode,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic                    frame_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    stale
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic                    cap;
  logic [IW-1:0]           cap_idx;
  logic [7:0]              cap_seg;
  logic [4:0]              dec;
  logic [4*NUM_DIGITS-1:0] pend_bcd, nxt_bcd;
  logic [NUM_DIGITS-1:0]   pend_dp, nxt_dp;
  logic [NUM_DIGITS-1:0]   pend_err, nxt_err;
  logic [NUM_DIGITS-1:0]   mask, nxt_mask;
  logic [TW-1:0]           tcnt, tcnt_n;

  seg_stability_filter #(
    .NUM_DIGITS   (NUM_DIGITS),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .rst    (reset),
    .seg_in (SevenSeg),
    .an_in  (Anode),
    .cap    (cap),
    .cap_idx(cap_idx),
    .cap_seg(cap_seg)
  );

  // Merge this cycle's capture so a completing frame includes it
  always_comb begin
    dec      = decode(~cap_seg[6:0]);
    nxt_bcd  = pend_bcd;
    nxt_dp   = pend_dp;
    nxt_err  = pend_err;
    nxt_mask = mask;
    if (cap) begin
      nxt_bcd[4*int'(cap_idx) +: 4] = dec[3:0];
      nxt_dp[cap_idx]               = ~cap_seg[SEG_DP];
      nxt_err[cap_idx]              = dec[4];
      nxt_mask[cap_idx]             = 1'b1;
    end
    if (cap)                             tcnt_n = '0;
    else if (tcnt == TW'(TIMEOUT_CYCLES)) tcnt_n = tcnt;
    else                                 tcnt_n = tcnt + TW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_bcd    <= '0;
      pend_dp     <= '0;
      pend_err    <= '0;
      mask        <= '0;
      tcnt        <= '0;
      bcd_out     <= '0;
      dp_out      <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      stale       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      tcnt        <= tcnt_n;
      stale       <= (tcnt_n == TW'(TIMEOUT_CYCLES));
      pend_bcd    <= nxt_bcd;
      pend_dp     <= nxt_dp;
      if (&mask) begin
        bcd_out     <= nxt_bcd;
        dp_out      <= nxt_dp;
        digit_err   <= nxt_err;
        frame_valid <= 1'b1;
        mask        <= '0;
        pend_err    <= '0;
      end else begin
        mask     <= nxt_mask;
        pend_err <= nxt_err;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_decoder.sv
// Directed self-checking bench for sevenseg_decoder (TIMEOUT_CYCLES=50).
module tb_sevenseg_decoder;

  logic        clk;
  logic        reset;
  logic [7:0]  SevenSeg;
  logic [3:0]  Anode;
  logic [15:0] bcd_out;
  logic [3:0]  dp_out;
  logic        frame_valid;
  logic [3:0]  digit_err;
  logic        stale;

  int checks;
  int errors;
  int fv_cnt;
  int fv_base;

  sevenseg_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (8),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .SevenSeg   (SevenSeg),
    .Anode      (Anode),
    .bcd_out    (bcd_out),
    .dp_out     (dp_out),
    .frame_valid(frame_valid),
    .digit_err  (digit_err),
    .stale      (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

  // Drive a bus value for n rising edges, then settle 1 time unit past the edge
  task automatic show(input logic [7:0] s, input logic [3:0] a, input int n);
    SevenSeg = s;
    Anode    = a;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (bcd_out !== 16'h0) begin errors++; $display("FAIL rst_bcd got %h exp 0000", bcd_out); end
    checks++; if (dp_out !== 4'h0) begin errors++; $display("FAIL rst_dp got %b exp 0000", dp_out); end
    checks++; if (digit_err !== 4'h0) begin errors++; $display("FAIL rst_err got %b exp 0000", digit_err); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_fv got %b exp 0", frame_valid); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rst_stale got %b exp 0", stale); end
  endtask

  task automatic test_loopback;
    fv_base = fv_cnt;
    show(8'hF9, 4'b1110, 10);
    show(8'hA4, 4'b1101, 10);
    show(8'hB0, 4'b1011, 10);
    show(8'h99, 4'b0111, 10);
    show(8'hFF, 4'b1111, 5);
    checks++; if (fv_cnt - fv_base !== 1) begin errors++; $display("FAIL loop_pulses got %0d exp 1", fv_cnt - fv_base); end
    checks++; if (bcd_out !== 16'h4321) begin errors++; $display("FAIL loop_bcd got %h exp 4321", bcd_out); end
    checks++; if (dp_out !== 4'h0) begin errors++; $display("FAIL loop_dp got %b exp 0000", dp_out); end
    checks++; if (digit_err !== 4'h0) begin errors++; $display("FAIL loop_err got %b exp 0000", digit_err); end
  endtask

  task automatic test_reset_mid_settle;
    show(8'hC0, 4'b1110, 5);
    reset = 1'b1;
    #1;
    checks++; if (bcd_out !== 16'h0) begin errors++; $display("FAIL midrst_bcd got %h exp 0000", bcd_out); end
    checks++; if (dp_out !== 4'h0 || digit_err !== 4'h0) begin errors++; $display("FAIL midrst_dp_err got %b/%b exp 0000/0000", dp_out, digit_err); end
    checks++; if (frame_valid !== 1'b0 || stale !== 1'b0) begin errors++; $display("FAIL midrst_fv_stale got %b/%b exp 0/0", frame_valid, stale); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    // 7 samples after release is one short of acceptance
    fv_base = fv_cnt;
    show(8'hC0, 4'b1110, 7);
    show(8'hC0, 4'b1111, 3);
    show(8'hF9, 4'b1101, 10);
    show(8'hA4, 4'b1011, 10);
    show(8'hB0, 4'b0111, 10);
    show(8'hFF, 4'b1111, 5);
    checks++; if (fv_cnt - fv_base !== 0) begin errors++; $display("FAIL midrst_short_hold got %0d pulses exp 0", fv_cnt - fv_base); end
    show(8'hC0, 4'b1110, 8);
    show(8'hFF, 4'b1111, 5);
    checks++; if (fv_cnt - fv_base !== 1) begin errors++; $display("FAIL midrst_restart got %0d pulses exp 1", fv_cnt - fv_base); end
    checks++; if (bcd_out !== 16'h3210) begin errors++; $display("FAIL midrst_bcd2 got %h exp 3210", bcd_out); end
  endtask

  task automatic test_glitch;
    show(8'h99, 4'b1101, 10);
    show(8'h92, 4'b1011, 10);
    show(8'h82, 4'b0111, 10);
    fv_base = fv_cnt;
    show(8'hC0, 4'b1110, 5);
    show(8'hF9, 4'b1110, 1);
    show(8'hC0, 4'b1110, 10);
    checks++; if (fv_cnt - fv_base !== 0 || frame_valid !== 1'b0) begin errors++; $display("FAIL glitch_early got %0d pulses fv=%b exp 0/0", fv_cnt - fv_base, frame_valid); end
    show(8'hC0, 4'b1110, 1);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL glitch_timing got fv=%b exp 1", frame_valid); end
    show(8'hFF, 4'b1111, 3);
    checks++; if (bcd_out !== 16'h6540) begin errors++; $display("FAIL glitch_bcd got %h exp 6540", bcd_out); end
    checks++; if (fv_cnt - fv_base !== 1) begin errors++; $display("FAIL glitch_pulses got %0d exp 1", fv_cnt - fv_base); end
  endtask

  task automatic test_bad_pattern;
    fv_base = fv_cnt;
    show(8'hC0, 4'b1110, 10);
    show(8'hF9, 4'b1101, 10);
    show(8'h7F, 4'b1011, 10);
    show(8'h99, 4'b0111, 10);
    show(8'hFF, 4'b1111, 5);
    checks++; if (fv_cnt - fv_base !== 1) begin errors++; $display("FAIL bad_pulses got %0d exp 1", fv_cnt - fv_base); end
    checks++; if (bcd_out !== 16'h4F10) begin errors++; $display("FAIL bad_bcd got %h exp 4f10", bcd_out); end
    checks++; if (digit_err !== 4'b0100) begin errors++; $display("FAIL bad_err got %b exp 0100", digit_err); end
    checks++; if (dp_out !== 4'b0100) begin errors++; $display("FAIL bad_dp got %b exp 0100", dp_out); end
  endtask

  task automatic test_blank_stale;
    fv_base = fv_cnt;
    show(8'hC0, 4'b1110, 10);   // digit 0 captured on the 10th edge
    show(8'hC0, 4'b1111, 20);
    show(8'hC0, 4'b1100, 20);
    show(8'hC0, 4'b1111, 9);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_early got %b exp 0", stale); end
    show(8'hC0, 4'b1111, 1);
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL stale_rise got %b exp 1", stale); end
    checks++; if (fv_cnt - fv_base !== 0) begin errors++; $display("FAIL blank_pulses got %0d exp 0", fv_cnt - fv_base); end
    show(8'hF9, 4'b1101, 9);
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL stale_hold got %b exp 1", stale); end
    show(8'hF9, 4'b1101, 1);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL stale_fall got %b exp 0", stale); end
  endtask

  task automatic test_overwrite;
    fv_base = fv_cnt;
    show(8'h92, 4'b1101, 10);
    show(8'hF8, 4'b1101, 10);
    show(8'hA4, 4'b1011, 10);
    show(8'hB0, 4'b0111, 10);
    show(8'hFF, 4'b1111, 5);
    checks++; if (fv_cnt - fv_base !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", fv_cnt - fv_base); end
    checks++; if (bcd_out !== 16'h3270) begin errors++; $display("FAIL ovr_bcd got %h exp 3270", bcd_out); end
    checks++; if (digit_err !== 4'h0 || dp_out !== 4'h0) begin errors++; $display("FAIL ovr_err_dp got %b/%b exp 0000/0000", digit_err, dp_out); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    fv_cnt   = 0;
    fv_base  = 0;
    reset    = 1'b1;
    SevenSeg = 8'hFF;
    Anode    = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    show(8'hFF, 4'b1111, 2);
    test_loopback;
    test_reset_mid_settle;
    test_glitch;
    test_bad_pattern;
    test_blank_stale;
    test_overwrite;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
